// File: rtl/wb_compressor_param_if.sv
// Core-side wishbone and compressed-bus signals of the wishbone compressor.
// The compressor uses the master modport; the core/pad environment uses slave.
interface wb_compressor_param_if #(
  parameter int unsigned CW_W      = 16,
  parameter int unsigned WB_DATA_W = 16,
  parameter int unsigned WB_ADDR_W = 24
);
  localparam int unsigned SEL_W = WB_DATA_W / 8;

  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [WB_ADDR_W-1:0] wb_adr;
  logic [WB_DATA_W-1:0] wb_o_dat;
  logic [SEL_W-1:0]     wb_sel;
  logic                 wb_4_burst;
  logic                 wb_8_burst;
  logic [WB_DATA_W-1:0] wb_i_dat;
  logic                 wb_ack;
  logic                 wb_err;

  logic [CW_W-1:0]      cw_io_o;
  logic [CW_W-1:0]      cw_io_i;
  logic                 cw_req;
  logic                 cw_dir;
  logic                 cw_ack;
  logic                 cw_err;

  modport master (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
    output wb_i_dat, wb_ack, wb_err,
    output cw_io_o, cw_req, cw_dir,
    input  cw_io_i, cw_ack, cw_err
  );

  modport slave (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
    input  wb_i_dat, wb_ack, wb_err,
    input  cw_io_o, cw_req, cw_dir,
    output cw_io_i, cw_ack, cw_err
  );
endinterface

// File: rtl/wb_compressor_param.sv
// Wishbone to compressed-bus master: serialises header, address and data into
// CW_W-wide beats, with per-word acks, error abort and response timeout.
module wb_compressor_param #(
  parameter int unsigned CW_W      = 16,
  parameter int unsigned WB_DATA_W = 16,
  parameter int unsigned WB_ADDR_W = 24,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  wb_compressor_param_if.master        bus,
  output logic                         o_busy
);
  localparam int unsigned SEL_W      = WB_DATA_W / 8;
  localparam int unsigned ADDR_BEATS = (WB_ADDR_W + CW_W - 1) / CW_W;
  localparam int unsigned DATA_BEATS = WB_DATA_W / CW_W;
  localparam int unsigned AW_PAD     = ADDR_BEATS * CW_W;
  localparam int unsigned TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {IDLE, HDR, ADDR, WDATA, WWAIT, RDATA} state_t;

  state_t               state;
  logic                 we_q;
  logic [2:0]           last_word;
  logic [2:0]           word_cnt;
  logic [7:0]           beat_cnt;
  logic                 loaded;
  logic [AW_PAD-1:0]    adr_sr;
  logic [WB_DATA_W-1:0] wd_sr;
  logic [WB_DATA_W-1:0] rd_buf;
  logic [WB_DATA_W-1:0] rd_next;
  logic [TW-1:0]        tmo_cnt;
  logic [CW_W-1:0]      hdr_beat;
  logic                 load_ok;
  logic                 tmo_hit;

  always_comb begin
    hdr_beat              = '0;
    hdr_beat[0]           = bus.wb_we;
    hdr_beat[2:1]         = bus.wb_8_burst ? 2'd2 : (bus.wb_4_burst ? 2'd1 : 2'd0);
    hdr_beat[3 +: SEL_W]  = bus.wb_sel;
    rd_next = (rd_buf >> CW_W) | (WB_DATA_W'(bus.cw_io_i) << (WB_DATA_W - CW_W));
    // Word data is taken only once the previous word's ack pulse has been seen,
    // so a registered master has had a cycle to present the next word.
    load_ok = bus.wb_stb && !bus.wb_ack;
    tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TMO_LAST));
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      last_word    <= '0;
      word_cnt     <= '0;
      beat_cnt     <= '0;
      loaded       <= 1'b0;
      adr_sr       <= '0;
      wd_sr        <= '0;
      rd_buf       <= '0;
      tmo_cnt      <= '0;
      bus.wb_i_dat <= '0;
      bus.wb_ack   <= 1'b0;
      bus.wb_err   <= 1'b0;
      bus.cw_io_o  <= '0;
      bus.cw_req   <= 1'b0;
      bus.cw_dir   <= 1'b0;
    end else begin
      bus.wb_ack <= 1'b0;
      bus.wb_err <= 1'b0;
      if (state != WWAIT && state != RDATA) tmo_cnt <= '0;

      unique case (state)
        IDLE: begin
          bus.cw_req  <= 1'b0;
          bus.cw_dir  <= 1'b0;
          bus.cw_io_o <= '0;
          if (bus.wb_cyc && bus.wb_stb) begin
            state       <= HDR;
            we_q        <= bus.wb_we;
            last_word   <= bus.wb_8_burst ? 3'd7 : (bus.wb_4_burst ? 3'd3 : 3'd0);
            word_cnt    <= '0;
            beat_cnt    <= '0;
            adr_sr      <= AW_PAD'(bus.wb_adr);
            bus.cw_req  <= 1'b1;
            bus.cw_dir  <= 1'b1;
            bus.cw_io_o <= hdr_beat;
          end
        end

        HDR: begin
          state       <= ADDR;
          beat_cnt    <= '0;
          bus.cw_io_o <= adr_sr[CW_W-1:0];
          adr_sr      <= adr_sr >> CW_W;
        end

        ADDR: begin
          if (beat_cnt == 8'(ADDR_BEATS - 1)) begin
            beat_cnt    <= '0;
            loaded      <= 1'b0;
            bus.cw_dir  <= 1'b0;
            bus.cw_io_o <= '0;
            if (we_q) begin
              state <= WDATA;
              if (load_ok) begin
                bus.cw_io_o <= bus.wb_o_dat[CW_W-1:0];
                wd_sr       <= bus.wb_o_dat >> CW_W;
                bus.cw_dir  <= 1'b1;
                loaded      <= 1'b1;
              end
            end else begin
              state <= RDATA;
            end
          end else begin
            beat_cnt    <= beat_cnt + 8'd1;
            bus.cw_io_o <= adr_sr[CW_W-1:0];
            adr_sr      <= adr_sr >> CW_W;
          end
        end

        WDATA: begin
          if (!loaded) begin
            if (load_ok) begin
              bus.cw_io_o <= bus.wb_o_dat[CW_W-1:0];
              wd_sr       <= bus.wb_o_dat >> CW_W;
              bus.cw_dir  <= 1'b1;
              loaded      <= 1'b1;
            end
          end else if (beat_cnt == 8'(DATA_BEATS - 1)) begin
            state       <= WWAIT;
            beat_cnt    <= '0;
            loaded      <= 1'b0;
            bus.cw_dir  <= 1'b0;
            bus.cw_io_o <= '0;
          end else begin
            beat_cnt    <= beat_cnt + 8'd1;
            bus.cw_io_o <= wd_sr[CW_W-1:0];
            wd_sr       <= wd_sr >> CW_W;
          end
        end

        WWAIT: begin
          if (bus.cw_err || (!bus.cw_ack && tmo_hit)) begin
            state      <= IDLE;
            bus.cw_req <= 1'b0;
            bus.wb_err <= bus.wb_cyc;
          end else if (bus.cw_ack) begin
            bus.wb_ack <= bus.wb_cyc;
            if (word_cnt == last_word) begin
              state      <= IDLE;
              bus.cw_req <= 1'b0;
            end else begin
              state    <= WDATA;
              word_cnt <= word_cnt + 3'd1;
              beat_cnt <= '0;
              loaded   <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        RDATA: begin
          if (bus.cw_err || (!bus.cw_ack && tmo_hit)) begin
            state      <= IDLE;
            bus.cw_req <= 1'b0;
            bus.wb_err <= bus.wb_cyc;
          end else if (bus.cw_ack) begin
            tmo_cnt <= '0;
            rd_buf  <= rd_next;
            if (beat_cnt == 8'(DATA_BEATS - 1)) begin
              beat_cnt     <= '0;
              bus.wb_i_dat <= rd_next;
              bus.wb_ack   <= bus.wb_cyc;
              if (word_cnt == last_word) begin
                state      <= IDLE;
                bus.cw_req <= 1'b0;
              end else begin
                word_cnt <= word_cnt + 3'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          state      <= IDLE;
          bus.cw_req <= 1'b0;
          bus.cw_dir <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_compressor_param.sv
// Directed bench for wb_compressor_param: default instance plus a TIMEOUT=4
// instance, checked with immediate assertions against hand-computed values.
module tb_wb_compressor_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy_t;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_compressor_param_if #(.CW_W(16), .WB_DATA_W(16), .WB_ADDR_W(24)) bus ();
  wb_compressor_param_if #(.CW_W(16), .WB_DATA_W(16), .WB_ADDR_W(24)) bus_t ();

  wb_compressor_param #(.CW_W(16), .WB_DATA_W(16), .WB_ADDR_W(24), .TIMEOUT(255)) u_dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus),
    .o_busy(busy)
  );

  wb_compressor_param #(.CW_W(16), .WB_DATA_W(16), .WB_ADDR_W(24), .TIMEOUT(4)) u_dut_t (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_t),
    .o_busy(busy_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    bus.wb_cyc = 0;   bus.wb_stb = 0;   bus.wb_we = 0;    bus.wb_adr = '0;
    bus.wb_o_dat = '0; bus.wb_sel = '0; bus.wb_4_burst = 0; bus.wb_8_burst = 0;
    bus.cw_io_i = '0; bus.cw_ack = 0;   bus.cw_err = 0;
    bus_t.wb_cyc = 0; bus_t.wb_stb = 0; bus_t.wb_we = 0;  bus_t.wb_adr = '0;
    bus_t.wb_o_dat = '0; bus_t.wb_sel = '0; bus_t.wb_4_burst = 0; bus_t.wb_8_burst = 0;
    bus_t.cw_io_i = '0; bus_t.cw_ack = 0; bus_t.cw_err = 0;
  endtask

  task automatic start(input logic we, input logic [23:0] adr, input logic [15:0] dat,
                       input logic b4, input logic b8);
    bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = we; bus.wb_adr = adr;
    bus.wb_o_dat = dat; bus.wb_sel = 2'b11; bus.wb_4_burst = b4; bus.wb_8_burst = b8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_bus();
    #12;
    chk("rst_req",  bus.cw_req, 0);
    chk("rst_dir",  bus.cw_dir, 0);
    chk("rst_io",   bus.cw_io_o, 0);
    chk("rst_ack",  bus.wb_ack, 0);
    chk("rst_err",  bus.wb_err, 0);
    chk("rst_idat", bus.wb_i_dat, 0);
    chk("rst_busy", busy, 0);
    #10 rst_n = 1;
    tick(); tick();

    // Single write: header, two address beats, one data beat, ack at cycle 7
    start(1, 24'hABCDEF, 16'h1234, 0, 0);
    tick(); chk("t1_hdr", bus.cw_io_o, 16'h0019); chk("t1_hdr_dir", bus.cw_dir, 1);
            chk("t1_hdr_req", bus.cw_req, 1);    chk("t1_busy1", busy, 1);
    tick(); chk("t1_adr0", bus.cw_io_o, 16'hCDEF);
    tick(); chk("t1_adr1", bus.cw_io_o, 16'h00AB);
    tick(); chk("t1_dat", bus.cw_io_o, 16'h1234); chk("t1_dat_dir", bus.cw_dir, 1);
    tick(); chk("t1_wait_dir", bus.cw_dir, 0); chk("t1_wait_req", bus.cw_req, 1);
    tick();
    tick(); bus.cw_ack = 1; chk("t1_no_early_ack", bus.wb_ack, 0);
    tick(); bus.cw_ack = 0;
            chk("t1_ack", bus.wb_ack, 1); chk("t1_idle", busy, 0); chk("t1_req_low", bus.cw_req, 0);
            bus.wb_cyc = 0; bus.wb_stb = 0;
    tick(); chk("t1_ack_pulse", bus.wb_ack, 0);

    // Single read: slave returns BEEF at cycle 6
    start(0, 24'h000010, 16'h0000, 0, 0);
    tick(); chk("t2_hdr", bus.cw_io_o, 16'h0018);
    tick(); chk("t2_adr0", bus.cw_io_o, 16'h0010);
    tick(); chk("t2_adr1", bus.cw_io_o, 16'h0000);
    tick(); chk("t2_dir", bus.cw_dir, 0); chk("t2_req", bus.cw_req, 1);
    tick();
    tick(); bus.cw_ack = 1; bus.cw_io_i = 16'hBEEF;
    tick(); bus.cw_ack = 0; bus.cw_io_i = 16'h0000;
            chk("t2_ack", bus.wb_ack, 1); chk("t2_dat", bus.wb_i_dat, 16'hBEEF);
            chk("t2_idle", busy, 0);
            bus.wb_cyc = 0; bus.wb_stb = 0;
    tick(); chk("t2_dat_hold", bus.wb_i_dat, 16'hBEEF); chk("t2_ack_pulse", bus.wb_ack, 0);

    // 8-burst read, with 4-burst also set to show the 8-burst priority
    start(0, 24'h000020, 16'h0000, 1, 1);
    tick(); chk("t3_hdr", bus.cw_io_o, 16'h001C);
    tick(); tick();
    tick(); chk("t3_dir", bus.cw_dir, 0);
    for (int i = 0; i < 8; i++) begin
      bus.cw_ack = 1; bus.cw_io_i = 16'(i);
      tick();
      chk($sformatf("t3_ack%0d", i), bus.wb_ack, 1);
      chk($sformatf("t3_dat%0d", i), bus.wb_i_dat, 32'(i));
    end
    bus.cw_ack = 0; bus.cw_io_i = 16'h0000;
    chk("t3_req_low", bus.cw_req, 0); chk("t3_idle", busy, 0);
    bus.wb_cyc = 0; bus.wb_stb = 0;
    tick(); chk("t3_no_ninth_ack", bus.wb_ack, 0); chk("t3_req_still_low", bus.cw_req, 0);

    // 4-burst write, slave errors on word 2 together with ack
    start(1, 24'h000030, 16'h1111, 1, 0);
    tick(); chk("t5_hdr", bus.cw_io_o, 16'h001B);
    tick(); chk("t5_adr0", bus.cw_io_o, 16'h0030);
    tick();
    tick(); chk("t5_dat0", bus.cw_io_o, 16'h1111);
    tick(); bus.cw_ack = 1;
    tick(); bus.cw_ack = 0; chk("t5_ack0", bus.wb_ack, 1); chk("t5_stall_dir", bus.cw_dir, 0);
            bus.wb_o_dat = 16'h2222;
    tick(); chk("t5_ack0_pulse", bus.wb_ack, 0); chk("t5_stall_dir2", bus.cw_dir, 0);
    tick(); chk("t5_dat1", bus.cw_io_o, 16'h2222); chk("t5_dat1_dir", bus.cw_dir, 1);
    tick(); chk("t5_wait_dir", bus.cw_dir, 0); bus.cw_ack = 1; bus.cw_err = 1;
    tick(); bus.cw_ack = 0; bus.cw_err = 0;
            chk("t5_err", bus.wb_err, 1); chk("t5_no_ack", bus.wb_ack, 0);
            chk("t5_idle", busy, 0); chk("t5_req_low", bus.cw_req, 0);
            bus.wb_cyc = 0; bus.wb_stb = 0;
    tick(); chk("t5_err_pulse", bus.wb_err, 0); chk("t5_no_more_dir", bus.cw_dir, 0);
    tick(); chk("t5_no_more_req", bus.cw_req, 0);

    // Timeout instance: single write, no slave response
    bus_t.wb_cyc = 1; bus_t.wb_stb = 1; bus_t.wb_we = 1; bus_t.wb_adr = 24'h000040;
    bus_t.wb_o_dat = 16'h5555; bus_t.wb_sel = 2'b11;
    tick(); chk("t4_hdr", bus_t.cw_io_o, 16'h0019);
    tick(); tick();
    tick(); chk("t4_dat", bus_t.cw_io_o, 16'h5555);
    tick(); chk("t4_wait_req", bus_t.cw_req, 1);
    tick(); tick();
    tick(); chk("t4_no_early_err", bus_t.wb_err, 0); chk("t4_busy", busy_t, 1);
    tick(); chk("t4_err", bus_t.wb_err, 1); chk("t4_req_low", bus_t.cw_req, 0);
            chk("t4_idle", busy_t, 0);
            bus_t.wb_cyc = 0; bus_t.wb_stb = 0;
    tick(); chk("t4_err_pulse", bus_t.wb_err, 0); chk("t4_req_low2", bus_t.cw_req, 0);

    // Asynchronous reset in the middle of the address phase, then a clean write
    start(1, 24'hABCDEF, 16'h1234, 0, 0);
    tick();
    tick(); chk("t6_in_addr", bus.cw_io_o, 16'hCDEF);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_req", bus.cw_req, 0); chk("t6_rst_dir", bus.cw_dir, 0);
    chk("t6_rst_io", bus.cw_io_o, 0); chk("t6_rst_ack", bus.wb_ack, 0);
    chk("t6_rst_busy", busy, 0);
    bus.wb_cyc = 0; bus.wb_stb = 0;
    #3 rst_n = 1;
    tick();
    start(1, 24'h000055, 16'hA5A5, 0, 0);
    tick(); chk("t6_hdr", bus.cw_io_o, 16'h0019);
    tick(); chk("t6_adr0", bus.cw_io_o, 16'h0055);
    tick(); chk("t6_adr1", bus.cw_io_o, 16'h0000);
    tick(); chk("t6_dat", bus.cw_io_o, 16'hA5A5);
    tick(); bus.cw_ack = 1;
    tick(); bus.cw_ack = 0; chk("t6_ack", bus.wb_ack, 1); chk("t6_idle", busy, 0);
            bus.wb_cyc = 0; bus.wb_stb = 0;
    tick(); chk("t6_ack_pulse", bus.wb_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
